i2c_slave: RTL and testbench
============================

# i2c_slave

Single-target I2C slave (responder) for one-byte write and one-byte read transactions without register addressing. It oversamples SCL/SDA on the system clock, answers its own 7-bit address, delivers a written byte to user logic and returns a user-supplied byte on reads. It is the far-end counterpart of the team's single-byte I2C master and is used as its loopback partner in simulation and on board.

## Interface
- `ADDR`, default 7'h50: own 7-bit slave address.
- `clk`  input  1  system clock; must run at least 8x the SCL frequency.
- `rst`  input  1  synchronous, active-high reset.
- `scl`  input  1  I2C clock from master (asynchronous to `clk`).
- `sda`  inout  1  I2C data; open drain: driven 0 or released (`1'bz`), never driven 1.
- `tx_data`  input  8  byte returned on a read; sampled once per read transaction.
- `rx_data`  output  8  last byte written by the master; reset 8'h00.
- `rx_valid`  output  1  one-`clk` pulse when `rx_data` updates; reset 0.
- `tx_load`  output  1  one-`clk` pulse when `tx_data` is captured; reset 0.
- `busy`  output  1  high from address match until STOP or return to IDLE; reset 0.

## Operation
- SCL and SDA each pass through a 2-FF synchronizer; edge flags (`scl_rise`, `scl_fall`) come from comparing synchronized value with its previous sample.
- START/repeated START: synchronized SDA falls while SCL high. STOP: SDA rises while SCL high. Both take priority over bit handling in every state.
- Bits are sampled on `scl_rise`; SDA drive changes only on `scl_fall`. MSB first.
- States:
  - IDLE: SDA released. START -> ADDR.
  - ADDR: shift 8 bits (7 address + R/W). After 8th rise: match -> ADDR_ACK, else -> WAIT_STOP.
  - ADDR_ACK: on entering `scl_fall` drive SDA 0, `busy`=1; if R/W=1 capture `tx_data` into shift register, pulse `tx_load`. On following `scl_fall`: R/W=0 -> WRITE (release SDA); R/W=1 -> READ (drive bit 7).
  - WRITE: shift 8 bits; after 8th rise update `rx_data`, pulse `rx_valid` next cycle -> WRITE_ACK.
  - WRITE_ACK: drive 0 for the 9th clock, then release -> WAIT_STOP (further bytes are NACKed).
  - READ: drive shift-register bits on each `scl_fall` (bit value 1 = release); after 8th bit's `scl_fall` release -> READ_ACK.
  - READ_ACK: sample master ACK/NACK on `scl_rise` (either value) -> WAIT_STOP.
  - WAIT_STOP: SDA released; wait for STOP or repeated START.
- Repeated START in any state -> ADDR, bit counter cleared, SDA released, `busy` cleared. This handles the master's write-address / restart / read-address sequence.
- STOP in any state -> IDLE, SDA released, `busy`=0. A partial byte is discarded; `rx_data` is unchanged.
- Reset mid-transfer: IDLE next cycle, SDA released, all outputs at reset values. The bus is not re-synchronized until the next START.

## Timing
- Input latency: 2 `clk` synchronizer + 1 `clk` edge detect. SDA drive updates on the 3rd `clk` after the physical SCL fall, well inside the low phase given the 8x ratio.
- `rx_valid` is asserted the `clk` after the 8th data `scl_rise` is detected, and `rx_data` is stable from the same cycle.
- `tx_load` pulses in the cycle ACK drive starts for a matching read address. `tx_data` must be valid then.
- Bit counter is 3 bits, counting 7 down to 0. Wrap at 0 ends the byte.

## Structure
- Shared package `i2c_pkg`: state encodings, `I2C_ADDR_W`=7, R/W bit values (W=0, R=1).
- Sub-module `i2c_sync_edge`: 2-FF synchronizer plus rise/fall detector. Instantiated twice (SCL, SDA).

## Test plan
- Write 8'hA5 to ADDR 7'h50 -> ACK on address and data, `rx_data`=8'hA5, one `rx_valid` pulse, `busy` drops after STOP.
- Read with restart (addr 7'h50 W, Sr, 7'h50 R) and `tx_data`=8'h3C -> two address ACKs, one `tx_load` pulse, master receives 8'h3C.
- Address 7'h51 -> SDA never driven low, no `rx_valid`/`tx_load`, `busy` stays 0.
- Write followed by a second byte 8'hFF -> second byte NACKed, `rx_data` remains 8'hA5.
- STOP after 4 data bits -> IDLE, `rx_data` unchanged, no `rx_valid`. Next full write of 8'h01 succeeds.
- `rst` asserted during READ bit 3 -> SDA released next `clk`, outputs at reset values. Subsequent write of 8'h5A is received correctly.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared constants for the single-byte I2C slave.
//   I2C_ADDR_W  - width of the 7-bit target address
//   RW_WRITE/RW_READ - value of the R/W bit following the address
//   ST_*        - FSM state encodings used by i2c_slave
`timescale 1ns/1ps
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ADDR      = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK  = 3'd2;
  localparam logic [2:0] ST_WRITE     = 3'd3;
  localparam logic [2:0] ST_WRITE_ACK = 3'd4;
  localparam logic [2:0] ST_READ      = 3'd5;
  localparam logic [2:0] ST_READ_ACK  = 3'd6;
  localparam logic [2:0] ST_WAIT_STOP = 3'd7;

endpackage

// File: rtl/i2c_sync_edge.sv
// i2c_sync_edge: two-flop synchronizer for an asynchronous bus line plus
// rise/fall detection against the previous synchronized sample.
//   clk    - system clock
//   rst    - synchronous active-high reset (line assumed idle-high)
//   d_i    - asynchronous input line
//   q_o    - synchronized level
//   rise_o - one-cycle flag, synchronized level went 0 -> 1
//   fall_o - one-cycle flag, synchronized level went 1 -> 0
`timescale 1ns/1ps
module i2c_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Reset to 1 so an idle bus does not produce a spurious edge afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign q_o    = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/i2c_slave.sv
// i2c_slave: single-target I2C responder for one-byte writes and reads.
//   clk      - system clock, at least 8x SCL
//   rst      - synchronous active-high reset
//   scl      - I2C clock from the master (asynchronous)
//   sda      - I2C data, open drain (driven 0 or released)
//   tx_data  - byte returned on a read, captured at address ACK
//   rx_data  - last byte written by the master
//   rx_valid - one-cycle pulse when rx_data updates
//   tx_load  - one-cycle pulse when tx_data is captured
//   busy     - high from address ACK until STOP / restart
//
// state        | meaning
// IDLE         | bus free, waiting for START
// ADDR         | shifting 7-bit address + R/W
// ADDR_ACK     | driving address ACK (9th clock)
// WRITE        | shifting in the data byte
// WRITE_ACK    | driving data ACK (9th clock)
// READ         | shifting out the tx byte
// READ_ACK     | sampling master ACK/NACK
// WAIT_STOP    | released, waiting for STOP or repeated START
`timescale 1ns/1ps
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_load,
  output logic       busy
);

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;

  i2c_sync_edge u_scl_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (scl),
    .q_o    (scl_s),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_sync_edge u_sda_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (sda),
    .q_o    (sda_s),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  logic       start_det, stop_det;
  logic [2:0] state_q, state_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] shift_in;
  logic       rw_q, rw_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_load_q, tx_load_d;
  logic       busy_q, busy_d;

  assign start_det = sda_fall & scl_s;
  assign stop_det  = sda_rise & scl_s;
  assign shift_in  = {shift_q[6:0], sda_s};

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_load_d  = 1'b0;
    busy_d     = busy_q;

    if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d  = ST_ADDR;
      bitcnt_d = 3'd7;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: if (scl_rise) begin
          shift_d  = shift_in;
          bitcnt_d = bitcnt_q - 3'd1;
          if (bitcnt_q == 3'd0) begin
            rw_d    = sda_s;
            state_d = (shift_in[7:1] == ADDR) ? ST_ADDR_ACK : ST_WAIT_STOP;
          end
        end
        // sda_oe_q distinguishes the fall that starts the ACK from the one ending it.
        ST_ADDR_ACK: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
            busy_d   = 1'b1;
            if (rw_q == RW_READ) begin
              shift_d   = tx_data;
              tx_load_d = 1'b1;
            end
          end else if (rw_q == RW_READ) begin
            state_d  = ST_READ;
            sda_oe_d = ~shift_q[7];
            shift_d  = {shift_q[6:0], 1'b0};
            bitcnt_d = 3'd7;
          end else begin
            state_d  = ST_WRITE;
            sda_oe_d = 1'b0;
            bitcnt_d = 3'd7;
          end
        end
        ST_WRITE: if (scl_rise) begin
          shift_d  = shift_in;
          bitcnt_d = bitcnt_q - 3'd1;
          if (bitcnt_q == 3'd0) begin
            rx_data_d  = shift_in;
            rx_valid_d = 1'b1;
            state_d    = ST_WRITE_ACK;
          end
        end
        ST_WRITE_ACK: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = ST_WAIT_STOP;
          end
        end
        // Bit 7 went out on entry; seven more falls drive bits 6..0, the next releases.
        ST_READ: if (scl_fall) begin
          if (bitcnt_q == 3'd0) begin
            sda_oe_d = 1'b0;
            state_d  = ST_READ_ACK;
          end else begin
            sda_oe_d = ~shift_q[7];
            shift_d  = {shift_q[6:0], 1'b0};
            bitcnt_d = bitcnt_q - 3'd1;
          end
        end
        ST_READ_ACK: if (scl_rise) begin
          state_d = ST_WAIT_STOP;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bitcnt_q   <= 3'd7;
      shift_q    <= 8'h00;
      rw_q       <= RW_WRITE;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_load_q  <= tx_load_d;
      busy_q     <= busy_d;
    end
  end

  assign sda      = sda_oe_q ? 1'b0 : 1'bz;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_load  = tx_load_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: directed bit-banged I2C master against i2c_slave, with
// expected rx bytes / tx_load events queued by the stimulus and checked by
// an independent monitor on the DUT outputs.
`timescale 1ns/1ps
module tb_i2c_slave;

  localparam int Q = 50;  // quarter SCL period; SCL = 200 ns, clk = 10 ns

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_load;
  logic       busy;
  wire        sda_w;

  assign sda_w = m_low ? 1'b0 : 1'bz;
  pullup (sda_w);

  always #5 clk = ~clk;

  i2c_slave #(.ADDR(7'h50)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl      (scl),
    .sda      (sda_w),
    .tx_data  (tx_data),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_load  (tx_load),
    .busy     (busy)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] exp_rx[$];
  logic       exp_tx[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every rx_valid / tx_load pulse must match a queued expectation.
  always @(negedge clk) begin
    logic [7:0] e;
    logic       lv;
    if (rx_valid) begin
      if (exp_rx.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rx_valid: got pulse with rx_data=%h, required no pulse at %0t", rx_data, $time);
      end else begin
        e = exp_rx.pop_front();
        check("rx_data_on_valid", {24'h0, rx_data}, {24'h0, e});
      end
    end
    if (tx_load) begin
      if (exp_tx.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_tx_load: got pulse, required no pulse at %0t", $time);
      end else begin
        lv = exp_tx.pop_front();
        check("tx_load_with_ack_drive", {31'h0, sda_w}, {31'h0, lv});
      end
    end
  end

  task automatic write_bit(input logic b);
    #(Q); m_low = ~b;
    #(Q); scl = 1'b1;
    #(2*Q); scl = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    #(Q); m_low = 1'b0;
    #(Q); scl = 1'b1;
    #(Q); b = sda_w;
    #(Q); scl = 1'b0;
  endtask

  task automatic start_c();
    #(Q); m_low = 1'b0;
    #(Q); scl = 1'b1;
    #(Q); m_low = 1'b1;
    #(Q); scl = 1'b0;
  endtask

  task automatic stop_c();
    #(Q); m_low = 1'b1;
    #(Q); scl = 1'b1;
    #(Q); m_low = 1'b0;
    #(2*Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic [7:0] rd;
    logic [3:0] nib;
    logic       b;

    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_rx_data", {24'h0, rx_data}, 32'h00);
    check("reset_rx_valid", {31'h0, rx_valid}, 32'h0);
    check("reset_tx_load", {31'h0, tx_load}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_sda", {31'h0, sda_w}, 32'h1);

    // 1: write A5
    exp_rx.push_back(8'hA5);
    start_c();
    write_byte(8'hA0, ack); check("w1_addr_ack", {31'h0, ack}, 32'h0);
    check("w1_busy", {31'h0, busy}, 32'h1);
    write_byte(8'hA5, ack); check("w1_data_ack", {31'h0, ack}, 32'h0);
    stop_c();
    check("w1_busy_after_stop", {31'h0, busy}, 32'h0);
    check("w1_rx_data", {24'h0, rx_data}, 32'hA5);
    check("w1_rx_q_empty", exp_rx.size(), 32'd0);

    // 2: write-address, restart, read-address, read 3C
    tx_data = 8'h3C;
    exp_tx.push_back(1'b0);
    start_c();
    write_byte(8'hA0, ack); check("r2_waddr_ack", {31'h0, ack}, 32'h0);
    start_c();
    write_byte(8'hA1, ack); check("r2_raddr_ack", {31'h0, ack}, 32'h0);
    read_byte(rd);
    check("r2_read_byte", {24'h0, rd}, 32'h3C);
    write_bit(1'b1);
    stop_c();
    check("r2_busy_after_stop", {31'h0, busy}, 32'h0);
    check("r2_tx_q_empty", exp_tx.size(), 32'd0);

    // 3: foreign address 51
    start_c();
    write_byte(8'hA2, ack); check("n3_addr_nack", {31'h0, ack}, 32'h1);
    check("n3_busy", {31'h0, busy}, 32'h0);
    write_byte(8'h00, ack); check("n3_data_nack", {31'h0, ack}, 32'h1);
    check("n3_busy_late", {31'h0, busy}, 32'h0);
    stop_c();
    check("n3_rx_data", {24'h0, rx_data}, 32'hA5);

    // 4: second byte is NACKed
    exp_rx.push_back(8'hA5);
    start_c();
    write_byte(8'hA0, ack); check("w4_addr_ack", {31'h0, ack}, 32'h0);
    write_byte(8'hA5, ack); check("w4_data_ack", {31'h0, ack}, 32'h0);
    write_byte(8'hFF, ack); check("w4_second_nack", {31'h0, ack}, 32'h1);
    stop_c();
    check("w4_rx_data", {24'h0, rx_data}, 32'hA5);
    check("w4_rx_q_empty", exp_rx.size(), 32'd0);

    // 5: STOP after 4 data bits, then full write of 01
    start_c();
    write_byte(8'hA0, ack); check("p5_addr_ack", {31'h0, ack}, 32'h0);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    stop_c();
    check("p5_rx_data_kept", {24'h0, rx_data}, 32'hA5);
    check("p5_busy", {31'h0, busy}, 32'h0);
    exp_rx.push_back(8'h01);
    start_c();
    write_byte(8'hA0, ack); check("p5b_addr_ack", {31'h0, ack}, 32'h0);
    write_byte(8'h01, ack); check("p5b_data_ack", {31'h0, ack}, 32'h0);
    stop_c();
    check("p5b_rx_data", {24'h0, rx_data}, 32'h01);
    check("p5b_rx_q_empty", exp_rx.size(), 32'd0);

    // 6: reset during read bit 3 (tx_data 00 so the slave is driving low)
    tx_data = 8'h00;
    exp_tx.push_back(1'b0);
    start_c();
    write_byte(8'hA1, ack); check("x6_addr_ack", {31'h0, ack}, 32'h0);
    for (int i = 3; i >= 0; i--) begin
      read_bit(b);
      nib[i] = b;
    end
    check("x6_bits_7_4", {28'h0, nib}, 32'h0);
    #(2*Q);
    check("x6_bit3_driven", {31'h0, sda_w}, 32'h0);
    scl = 1'b1;
    #(Q);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("x6_sda_released", {31'h0, sda_w}, 32'h1);
    check("x6_rx_data_reset", {24'h0, rx_data}, 32'h00);
    check("x6_busy_reset", {31'h0, busy}, 32'h0);
    check("x6_rx_valid_reset", {31'h0, rx_valid}, 32'h0);
    check("x6_tx_load_reset", {31'h0, tx_load}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    check("x6_tx_q_empty", exp_tx.size(), 32'd0);
    #(Q);
    scl = 1'b0;
    exp_rx.push_back(8'h5A);
    start_c();
    write_byte(8'hA0, ack); check("x6b_addr_ack", {31'h0, ack}, 32'h0);
    write_byte(8'h5A, ack); check("x6b_data_ack", {31'h0, ack}, 32'h0);
    stop_c();
    check("x6b_rx_data", {24'h0, rx_data}, 32'h5A);
    check("x6b_busy", {31'h0, busy}, 32'h0);
    check("x6b_rx_q_empty", exp_rx.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
